// File: rtl/color_match_judge_if.sv
// Handshake and render bus between the randomizer/game logic and color_match_judge.
// The judge takes the slave side. The supplier of colours and landings takes the master side.
interface color_match_judge_if #(
   parameter int SCORE_W = 8
);
   logic               start;
   logic               colors_valid;
   logic [2:0]         ball_color_in;
   logic [11:0]        plat_colors_in;
   logic               land;
   logic [1:0]         land_lane;
   logic               req_colors;
   logic [2:0]         ball_color;
   logic [11:0]        plat_colors;
   logic               hit;
   logic               miss;
   logic [SCORE_W-1:0] score;
   logic [2:0]         lives;
   logic               game_over;

   modport slave (
      input  start, colors_valid, ball_color_in, plat_colors_in, land, land_lane,
      output req_colors, ball_color, plat_colors, hit, miss, score, lives, game_over
   );

   modport master (
      output start, colors_valid, ball_color_in, plat_colors_in, land, land_lane,
      input  req_colors, ball_color, plat_colors, hit, miss, score, lives, game_over
   );
endinterface

// File: rtl/color_match_judge.sv
// Colour match judge: fetches colour sets, judges ball vs. landed platform, keeps score/lives.
// Moore FSM; every output comes straight from a register.
module color_match_judge #(
   parameter int SCORE_W      = 8,
   parameter int LIVES_INIT   = 3,
   parameter int FLASH_CYCLES = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   color_match_judge_if.slave   bus
);
   localparam int                 CNT_W     = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [2:0]         LIVES_RST = 3'(LIVES_INIT);

   typedef enum logic [2:0] {IDLE, REQ, PLAY, JUDGE, FLASH, OVER} state_t;

   state_t             state_q;
   logic               req_q, hit_q, miss_q, over_q;
   logic [2:0]         ball_q;
   logic [11:0]        plat_q;
   logic [SCORE_W-1:0] score_q;
   logic [2:0]         lives_q;
   logic [1:0]         lane_q;
   logic [CNT_W-1:0]   cnt_q;

   logic plat_ok, any_eq, set_ok, match;

   // A set is playable only if every colour is non-black and the ball has a landing spot.
   always_comb begin
      plat_ok = 1'b1;
      any_eq  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (bus.plat_colors_in[3*k +: 3] == 3'd0)               plat_ok = 1'b0;
         if (bus.plat_colors_in[3*k +: 3] == bus.ball_color_in)  any_eq  = 1'b1;
      end
   end

   assign set_ok = (bus.ball_color_in != 3'd0) && plat_ok && any_eq;
   assign match  = (plat_q[3*int'(lane_q) +: 3] == ball_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         over_q  <= 1'b0;
         ball_q  <= '0;
         plat_q  <= '0;
         score_q <= '0;
         lives_q <= LIVES_RST;
         lane_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.start) begin
               score_q <= '0;
               lives_q <= LIVES_RST;
               req_q   <= 1'b1;
               state_q <= REQ;
            end
            REQ: if (req_q && bus.colors_valid && set_ok) begin
               ball_q  <= bus.ball_color_in;
               plat_q  <= bus.plat_colors_in;
               req_q   <= 1'b0;
               state_q <= PLAY;
            end
            PLAY: if (bus.land) begin
               lane_q  <= bus.land_lane;
               state_q <= JUDGE;
            end
            JUDGE: begin
               if (match) begin
                  hit_q <= 1'b1;
                  if (score_q != SCORE_MAX) score_q <= score_q + 1'b1;
               end else begin
                  miss_q <= 1'b1;
                  if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
               end
               cnt_q   <= CNT_W'(FLASH_CYCLES - 1);
               state_q <= FLASH;
            end
            FLASH: begin
               if (cnt_q == '0) begin
                  hit_q  <= 1'b0;
                  miss_q <= 1'b0;
                  if (lives_q == 3'd0) begin
                     over_q  <= 1'b1;
                     state_q <= OVER;
                  end else begin
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            OVER: if (bus.start) begin
               over_q  <= 1'b0;
               score_q <= '0;
               lives_q <= LIVES_RST;
               req_q   <= 1'b1;
               state_q <= REQ;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_colors  = req_q;
   assign bus.ball_color  = ball_q;
   assign bus.plat_colors = plat_q;
   assign bus.hit         = hit_q;
   assign bus.miss        = miss_q;
   assign bus.score       = score_q;
   assign bus.lives       = lives_q;
   assign bus.game_over   = over_q;
endmodule

// File: tb/tb_color_match_judge.sv
// Directed bench for color_match_judge: a vector table of offered sets/landings plus
// hand sequences for game over, restart, saturation (SCORE_W=2 twin) and mid-game reset.
module tb_color_match_judge;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   color_match_judge_if #(.SCORE_W(8)) m_if ();
   color_match_judge_if #(.SCORE_W(2)) s_if ();

   color_match_judge #(.SCORE_W(8), .LIVES_INIT(3), .FLASH_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .bus(m_if)
   );
   color_match_judge #(.SCORE_W(2), .LIVES_INIT(3), .FLASH_CYCLES(4)) dut_sat (
      .clock(clock), .reset(reset), .bus(s_if)
   );

   assign s_if.start          = m_if.start;
   assign s_if.colors_valid   = m_if.colors_valid;
   assign s_if.ball_color_in  = m_if.ball_color_in;
   assign s_if.plat_colors_in = m_if.plat_colors_in;
   assign s_if.land           = m_if.land;
   assign s_if.land_lane      = m_if.land_lane;

   typedef struct {
      logic [2:0]  ball;
      logic [11:0] plats;
      logic        acc;
      logic [1:0]  lane;
      logic        exp_hit;
   } vec_t;

   vec_t        vecs [9];
   int          n_pass = 0;
   int          n_chk  = 0;
   logic [2:0]  m_ball  = '0;
   logic [11:0] m_plats = '0;
   int          m_score = 0;
   int          m_lives = 3;

   function automatic logic [11:0] pk(input logic [2:0] p3, p2, p1, p0);
      return {p3, p2, p1, p0};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " req"},   32'(m_if.req_colors),  0);
      check({tag, " hit"},   32'(m_if.hit),         0);
      check({tag, " miss"},  32'(m_if.miss),        0);
      check({tag, " over"},  32'(m_if.game_over),   0);
      check({tag, " ball"},  32'(m_if.ball_color),  0);
      check({tag, " plats"}, 32'(m_if.plat_colors), 0);
      check({tag, " score"}, 32'(m_if.score),       0);
      check({tag, " lives"}, 32'(m_if.lives),       3);
   endtask

   // Land on a lane from PLAY and follow the judge through the whole flash window.
   task automatic land_and_judge(input string tag, input logic [1:0] lane, input logic exp_hit);
      m_if.land = 1'b1;
      m_if.land_lane = lane;
      tick();
      check({tag, " judge quiet"}, 32'(m_if.hit | m_if.miss), 0);
      tick();
      if (exp_hit) m_score = (m_score < 255) ? m_score + 1 : 255;
      else if (m_lives > 0) m_lives--;
      check({tag, " hit"},   32'(m_if.hit),   32'(exp_hit));
      check({tag, " miss"},  32'(m_if.miss),  32'(!exp_hit));
      check({tag, " score"}, 32'(m_if.score), 32'(m_score));
      check({tag, " lives"}, 32'(m_if.lives), 32'(m_lives));
      for (int c = 0; c < 3; c++) begin
         m_if.land_lane = 2'(c);
         tick();
         check({tag, " flash held"}, 32'({m_if.hit, m_if.miss, m_if.req_colors}),
               exp_hit ? 32'b100 : 32'b010);
      end
      tick();
      m_if.land = 1'b0;
      check({tag, " flash end"}, 32'(m_if.hit | m_if.miss), 0);
      check({tag, " req after"}, 32'(m_if.req_colors), 32'(m_lives != 0));
      check({tag, " over"},      32'(m_if.game_over),  32'(m_lives == 0));
      check({tag, " score kept"}, 32'(m_if.score), 32'(m_score));
   endtask

   task automatic play_row(input string tag, input vec_t v);
      m_if.ball_color_in  = v.ball;
      m_if.plat_colors_in = v.plats;
      m_if.colors_valid   = 1'b1;
      tick();
      m_if.colors_valid = 1'b0;
      if (v.acc) begin
         m_ball  = v.ball;
         m_plats = v.plats;
      end
      check({tag, " req"},   32'(m_if.req_colors),  32'(!v.acc));
      check({tag, " ball"},  32'(m_if.ball_color),  32'(m_ball));
      check({tag, " plats"}, 32'(m_if.plat_colors), 32'(m_plats));
      if (v.acc) land_and_judge(tag, v.lane, v.exp_hit);
   endtask

   initial begin
      vec_t miss_v;
      vecs[0] = '{3'd2, pk(3'd1, 3'd4, 3'd2, 3'd5), 1'b1, 2'd1, 1'b1};
      vecs[1] = '{3'd0, pk(3'd1, 3'd4, 3'd2, 3'd5), 1'b0, 2'd0, 1'b0};
      vecs[2] = '{3'd3, pk(3'd1, 3'd4, 3'd2, 3'd5), 1'b0, 2'd0, 1'b0};
      vecs[3] = '{3'd4, pk(3'd1, 3'd4, 3'd0, 3'd4), 1'b0, 2'd0, 1'b0};
      vecs[4] = '{3'd6, pk(3'd6, 3'd1, 3'd2, 3'd3), 1'b1, 2'd0, 1'b0};
      vecs[5] = '{3'd7, pk(3'd7, 3'd7, 3'd7, 3'd7), 1'b1, 2'd2, 1'b1};
      vecs[6] = '{3'd1, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 2'd3, 1'b1};
      vecs[7] = '{3'd5, pk(3'd3, 3'd5, 3'd5, 3'd6), 1'b1, 2'd0, 1'b0};
      vecs[8] = '{3'd2, pk(3'd2, 3'd2, 3'd2, 3'd2), 1'b1, 2'd1, 1'b1};

      reset = 1'b1;
      m_if.start = 1'b0; m_if.colors_valid = 1'b0; m_if.ball_color_in = '0;
      m_if.plat_colors_in = '0; m_if.land = 1'b0; m_if.land_lane = '0;
      tick(); tick();
      reset = 1'b0;
      check_reset("por");
      tick();
      check("idle no req", 32'(m_if.req_colors), 0);

      m_if.start = 1'b1;
      tick();
      m_if.start = 1'b0;
      check("start req", 32'(m_if.req_colors), 1);

      for (int i = 0; i < 9; i++) play_row($sformatf("row%0d", i), vecs[i]);
      check("sat score w2", 32'(s_if.score), 3);
      check("score w8",     32'(m_if.score), 4);

      // Last life lost: ball 3 lands on lane 0 (colour 4).
      miss_v = '{3'd3, pk(3'd1, 3'd2, 3'd3, 3'd4), 1'b1, 2'd0, 1'b0};
      play_row("lastlife", miss_v);
      m_if.land = 1'b1;
      m_if.ball_color_in = 3'd7; m_if.plat_colors_in = pk(3'd7, 3'd7, 3'd7, 3'd7);
      m_if.colors_valid = 1'b1;
      tick(); tick();
      m_if.land = 1'b0; m_if.colors_valid = 1'b0;
      check("over held",   32'(m_if.game_over),  1);
      check("over score",  32'(m_if.score),      4);
      check("over lives",  32'(m_if.lives),      0);
      check("over ball",   32'(m_if.ball_color), 3);
      check("over quiet",  32'({m_if.hit, m_if.miss, m_if.req_colors}), 0);

      m_if.start = 1'b1;
      tick();
      m_if.start = 1'b0;
      m_score = 0; m_lives = 3;
      check("restart req",   32'(m_if.req_colors), 1);
      check("restart score", 32'(m_if.score),      0);
      check("restart lives", 32'(m_if.lives),      3);
      check("restart over",  32'(m_if.game_over),  0);

      miss_v = '{3'd1, pk(3'd1, 3'd2, 3'd2, 3'd2), 1'b1, 2'd0, 1'b0};
      for (int i = 0; i < 3; i++) play_row($sformatf("miss%0d", i), miss_v);

      m_if.start = 1'b1;
      tick();
      m_if.start = 1'b0;
      m_score = 0; m_lives = 3;
      check("restart2 lives", 32'(m_if.lives), 3);

      // Reset while flashing a hit.
      m_if.ball_color_in = 3'd2; m_if.plat_colors_in = pk(3'd2, 3'd2, 3'd2, 3'd2);
      m_if.colors_valid = 1'b1;
      tick();
      m_if.colors_valid = 1'b0;
      m_if.land = 1'b1; m_if.land_lane = 2'd0;
      tick();
      m_if.land = 1'b0;
      tick();
      check("pre-reset hit", 32'(m_if.hit), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset("rst flash");

      // Reset coincident with an acceptable handshake.
      m_if.start = 1'b1;
      tick();
      m_if.start = 1'b0;
      check("req before rst", 32'(m_if.req_colors), 1);
      m_if.ball_color_in = 3'd5; m_if.plat_colors_in = pk(3'd5, 3'd1, 3'd1, 3'd1);
      m_if.colors_valid = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset("rst req");
      tick();
      m_if.colors_valid = 1'b0;
      check("idle after rst", 32'({m_if.req_colors, m_if.ball_color}), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
